// File: rtl/systolic_input_fifo_bank_pkg.sv
// Shared types and sizing for the systolic array input buffering stage.
// Element width, array dimension and FIFO depth are fixed here for the whole slice.
package systolic_array_pkg;

  localparam int N         = 4;
  localparam int DW        = 16;
  localparam int DEPTH     = 3;
  localparam int ROW_IDX_W = $clog2(N);
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef logic [DW-1:0] elem_t;
  typedef elem_t [N-1:0] row_vec_t;

  // Pointer advance with explicit wrap, since DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/systolic_input_fifo_bank_if.sv
// Control-unit facing bus of the input FIFO bank: row loads, per-row shifts,
// array-side element outputs and status/error flags.
interface systolic_input_fifo_bank_if import systolic_array_pkg::*; ();

  logic                 input_load;
  logic [ROW_IDX_W-1:0] input_row;
  logic [N*DW-1:0]      load_data;
  logic [N-1:0]         fifo_shift;
  logic                 err_clr;
  logic [N*DW-1:0]      array_in;
  logic [N-1:0]         array_in_valid;
  logic [N-1:0]         row_full;
  logic [N-1:0]         row_empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output input_load, input_row, load_data, fifo_shift, err_clr,
    input  array_in, array_in_valid, row_full, row_empty, overflow, underflow
  );

  modport slave (
    input  input_load, input_row, load_data, fifo_shift, err_clr,
    output array_in, array_in_valid, row_full, row_empty, overflow, underflow
  );

endinterface

// File: rtl/systolic_input_fifo_bank_row_fifo.sv
// One row FIFO: holds up to DEPTH row vectors and streams the head vector
// one element per shift, popping it after the last element.
module input_row_fifo import systolic_array_pkg::*; (
  input  logic     clk,
  input  logic     RST,
  input  logic     wr_en,
  input  row_vec_t wr_data,
  input  logic     shift,
  output elem_t    out_elem,
  output logic     out_valid,
  output logic     full,
  output logic     empty,
  output logic     ovf_pulse,
  output logic     unf_pulse
);

  row_vec_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_next;
  logic [ROW_IDX_W-1:0] elem_idx;
  logic                 has_data, do_shift, pop, wr_ok;

  // A full row may still accept a write on the cycle its head pops.
  always_comb begin
    has_data   = (count != '0);
    do_shift   = shift && has_data;
    pop        = do_shift && (elem_idx == ROW_IDX_W'(N - 1));
    wr_ok      = wr_en && ((count < CNT_W'(DEPTH)) || pop);
    ovf_pulse  = wr_en && !wr_ok;
    unf_pulse  = shift && !has_data;
    count_next = count;
    if (wr_ok && !pop)      count_next = count + 1'b1;
    else if (pop && !wr_ok) count_next = count - 1'b1;
  end

  // NOTE: the vector storage is deliberately left unreset; valid data is
  // tracked by count/pointers, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      elem_idx  <= '0;
      out_elem  <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
      if (do_shift) begin
        out_elem  <= mem[rd_ptr][elem_idx];
        out_valid <= 1'b1;
        elem_idx  <= pop ? '0 : elem_idx + 1'b1;
      end else if (shift) begin
        out_elem  <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/systolic_input_fifo_bank.sv
// Per-row input buffering ahead of the systolic array: decodes row writes,
// fans out to N row FIFOs and keeps sticky overflow/underflow flags.
module systolic_input_fifo_bank import systolic_array_pkg::*; (
  input  logic                       clk,
  input  logic                       RST,
  systolic_input_fifo_bank_if.slave  bus
);

  logic [N-1:0]    wr_en, ovf, unf, out_valid, full, empty;
  elem_t           out_elem [N];
  row_vec_t        load_vec;
  logic            bad_row;
  logic [N*DW-1:0] array_in_w;
  logic            overflow_q, underflow_q;

  assign load_vec = row_vec_t'(bus.load_data);

  // A load that matches no row is an out-of-range index and is dropped.
  always_comb begin
    wr_en = '0;
    for (int r = 0; r < N; r++)
      wr_en[r] = bus.input_load && (bus.input_row == ROW_IDX_W'(r));
    bad_row = bus.input_load && (wr_en == '0);
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    input_row_fifo u_fifo (
      .clk       (clk),
      .RST       (RST),
      .wr_en     (wr_en[r]),
      .wr_data   (load_vec),
      .shift     (bus.fifo_shift[r]),
      .out_elem  (out_elem[r]),
      .out_valid (out_valid[r]),
      .full      (full[r]),
      .empty     (empty[r]),
      .ovf_pulse (ovf[r]),
      .unf_pulse (unf[r])
    );
  end

  always_comb begin
    array_in_w = '0;
    for (int r = 0; r < N; r++)
      array_in_w[r*DW +: DW] = out_elem[r];
  end

  // Clear wins over a same-cycle error event.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.err_clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if ((|ovf) || bad_row) overflow_q  <= 1'b1;
      if (|unf)              underflow_q <= 1'b1;
    end
  end

  assign bus.array_in       = array_in_w;
  assign bus.array_in_valid = out_valid;
  assign bus.row_full       = full;
  assign bus.row_empty      = empty;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

endmodule
